// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-source blocks.
// Holds the default visible-area size, the 6-bit RRGGBB colour type with its
// field positions, a small colour-building helper and the box FSM states.
package vga_pkg;

    localparam int H_VIS_DEF = 640;
    localparam int V_VIS_DEF = 480;

    typedef logic [5:0] colour_t;

    // RRGGBB field positions inside colour_t
    localparam int R_MSB = 5;
    localparam int R_LSB = 4;
    localparam int G_MSB = 3;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        S_DRAW   = 2'd0,
        S_MOVE_X = 2'd1,
        S_MOVE_Y = 2'd2
    } state_t;

    // Build a colour from three 2-bit channel intensities.
    function automatic colour_t rgb(input logic [1:0] r, input logic [1:0] g,
                                    input logic [1:0] b);
        colour_t c;
        c = '0;
        c[R_MSB:R_LSB] = r;
        c[G_MSB:G_LSB] = g;
        c[B_MSB:B_LSB] = b;
        return c;
    endfunction

    // Box colour after reset: full red
    localparam colour_t BOX_COL_RESET = rgb(2'b11, 2'b00, 2'b00);

endpackage

// File: rtl/axis_mover.sv
// One axis of the bouncing box: position and direction, updated by one step
// when step_en is high, reflecting off 0 and LIMIT-BOX.
// Ports:
//   vga_clock  pixel clock
//   reset      synchronous, active-high
//   step_en    perform one move this cycle
//   pos        current leading-edge position (10 bits)
//   dir        0 = increasing, 1 = decreasing
//   bounce     one-cycle pulse, high in the cycle a move hits an edge
module axis_mover #(
    parameter int LIMIT = 640,
    parameter int BOX   = 32,
    parameter int STEP  = 2,
    parameter int INIT  = 0
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       step_en,
    output logic [9:0] pos,
    output logic       dir,
    output logic       bounce
);

    localparam logic [10:0] MAX_POS = 11'(LIMIT - BOX);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    logic [9:0]  pos_reg, pos_next;
    logic        dir_reg, dir_next;
    logic [10:0] pos_ext;
    logic [10:0] fwd_sum;

    // 11-bit arithmetic so pos+STEP can never wrap
    assign pos_ext = {1'b0, pos_reg};
    assign fwd_sum = pos_ext + STEP_W;

    always_comb begin
        pos_next = pos_reg;
        dir_next = dir_reg;
        bounce   = 1'b0;
        if (step_en) begin
            if (!dir_reg) begin
                // Landing exactly on the far edge is a bounce too
                if (fwd_sum >= MAX_POS) begin
                    pos_next = MAX_POS[9:0];
                    dir_next = 1'b1;
                    bounce   = 1'b1;
                end else begin
                    pos_next = fwd_sum[9:0];
                end
            end else begin
                if (pos_ext <= STEP_W) begin
                    pos_next = '0;
                    dir_next = 1'b0;
                    bounce   = 1'b1;
                end else begin
                    pos_next = pos_reg - STEP_W[9:0];
                end
            end
        end
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            pos_reg <= 10'(INIT);
            dir_reg <= 1'b0;
        end else begin
            pos_reg <= pos_next;
            dir_reg <= dir_next;
        end
    end

    assign pos = pos_reg;
    assign dir = dir_reg;

endmodule

// File: rtl/bouncing_box_gen.sv
// Bouncing-box pixel source feeding vga_controller.
// Returns a registered colour for the current (x, y): 0 in blanking, the box
// colour inside the box, BG_COLOUR elsewhere. Once per frame (at x==0,
// y==V_VIS, if enable) the box moves one step on x then on y, during vertical
// blanking, and every edge hit advances the box colour and the bounce counter.
// Ports:
//   vga_clock     pixel clock
//   reset         synchronous, active-high
//   x, y          current pixel column / line, including blanking
//   enable        move each frame when high, freeze when low
//   colour        RRGGBB for the pixel presented one cycle earlier
//   bounce_count  bounces since reset, wraps at 256
module bouncing_box_gen
    import vga_pkg::*;
#(
    parameter int      H_VIS     = H_VIS_DEF,
    parameter int      V_VIS     = V_VIS_DEF,
    parameter int      BOX       = 32,
    parameter int      STEP      = 2,
    parameter int      INIT_X    = 0,
    parameter int      INIT_Y    = 0,
    parameter colour_t BG_COLOUR = 6'b000001
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       enable,
    output colour_t    colour,
    output logic [7:0] bounce_count
);

    state_t      state_reg, state_next;
    colour_t     box_col_reg, box_col_next;
    logic [7:0]  bounce_count_reg, bounce_count_next;
    colour_t     colour_reg, colour_next;

    logic        frame_end;
    logic [1:0]  step_en;
    logic [9:0]  pos_arr [2];
    logic [1:0]  unused_dir;   // direction lives inside each mover
    logic [1:0]  bounce_vec;
    logic [9:0]  px, py;

    assign frame_end = (x == 10'd0) && (y == 10'(V_VIS));

    // ---------------- FSM ----------------
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_reg <= S_DRAW;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_en    = 2'b00;
        case (state_reg)
            S_DRAW: begin
                if (frame_end && enable) begin
                    state_next = S_MOVE_X;
                end
            end
            S_MOVE_X: begin
                step_en[0] = 1'b1;
                state_next = S_MOVE_Y;
            end
            S_MOVE_Y: begin
                step_en[1] = 1'b1;
                state_next = S_DRAW;
            end
            default: state_next = S_DRAW;
        endcase
    end

    // ---------------- axis movers: 0 = x, 1 = y ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            axis_mover #(
                .LIMIT (gi == 0 ? H_VIS  : V_VIS),
                .BOX   (BOX),
                .STEP  (STEP),
                .INIT  (gi == 0 ? INIT_X : INIT_Y)
            ) u_mover (
                .vga_clock (vga_clock),
                .reset     (reset),
                .step_en   (step_en[gi]),
                .pos       (pos_arr[gi]),
                .dir       (unused_dir[gi]),
                .bounce    (bounce_vec[gi])
            );
        end
    endgenerate

    assign px = pos_arr[0];
    assign py = pos_arr[1];

    // ---------------- colour / bounce counters ----------------
    // x and y moves happen in different cycles, so at most one bounce per cycle
    always_comb begin
        box_col_next      = box_col_reg;
        bounce_count_next = bounce_count_reg;
        if (|bounce_vec) begin
            box_col_next      = colour_t'(box_col_reg + 6'd1);
            bounce_count_next = bounce_count_reg + 8'd1;
        end
    end

    // ---------------- pixel compare ----------------
    always_comb begin
        logic [10:0] x_ext, y_ext, px_ext, py_ext;
        x_ext  = {1'b0, x};
        y_ext  = {1'b0, y};
        px_ext = {1'b0, px};
        py_ext = {1'b0, py};
        colour_next = BG_COLOUR;
        if (x_ext >= 11'(H_VIS) || y_ext >= 11'(V_VIS)) begin
            colour_next = '0;
        end else if (x_ext >= px_ext && x_ext < px_ext + 11'(BOX) &&
                     y_ext >= py_ext && y_ext < py_ext + 11'(BOX)) begin
            colour_next = box_col_reg;
        end
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            box_col_reg      <= BOX_COL_RESET;
            bounce_count_reg <= '0;
            colour_reg       <= '0;
        end else begin
            box_col_reg      <= box_col_next;
            bounce_count_reg <= bounce_count_next;
            colour_reg       <= colour_next;
        end
    end

    assign colour       = colour_reg;
    assign bounce_count = bounce_count_reg;

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Self-checking bench for bouncing_box_gen. Three instances with different
// start positions share the same pixel/enable/reset stimulus; a behavioural
// model per instance predicts colour, bounce count and box position.
module tb_bouncing_box_gen;

    logic       vga_clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic [5:0] colour_a, colour_b, colour_c;
    logic [7:0] count_a, count_b, count_c;

    always #5 vga_clock = ~vga_clock;

    bouncing_box_gen dut_a (
        .vga_clock(vga_clock), .reset(reset), .x(x), .y(y), .enable(enable),
        .colour(colour_a), .bounce_count(count_a));

    bouncing_box_gen #(.INIT_X(606), .INIT_Y(100)) dut_b (
        .vga_clock(vga_clock), .reset(reset), .x(x), .y(y), .enable(enable),
        .colour(colour_b), .bounce_count(count_b));

    bouncing_box_gen #(.INIT_X(607), .INIT_Y(447)) dut_c (
        .vga_clock(vga_clock), .reset(reset), .x(x), .y(y), .enable(enable),
        .colour(colour_c), .bounce_count(count_c));

    int checks = 0;
    int passes = 0;

    // ---------------- reference model ----------------
    int init_x [3] = '{0, 606, 607};
    int init_y [3] = '{0, 100, 447};
    int m_px [3], m_py [3], m_dx [3], m_dy [3], m_col [3], m_cnt [3];
    int moves_pending = 0;   // axis moves still owed after a frame end: 2 = x then y

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_px[i] = init_x[i]; m_py[i] = init_y[i];
            m_dx[i] = 0; m_dy[i] = 0;
            m_col[i] = 48; m_cnt[i] = 0;
        end
        moves_pending = 0;
    endtask

    function automatic int exp_colour(int i, int xx, int yy);
        if (xx >= 640 || yy >= 480) return 0;
        if (xx >= m_px[i] && xx < m_px[i] + 32 && yy >= m_py[i] && yy < m_py[i] + 32)
            return m_col[i];
        return 1;
    endfunction

    // One step along an axis whose far edge is lim-32; returns 1 on a bounce.
    task automatic axis_step(input int p, input int d, input int lim,
                             output int np, output int nd, output bit hit);
        int far;
        far = lim - 32;
        np = p; nd = d; hit = 0;
        if (d == 0) begin
            if (p + 2 >= far) begin np = far; nd = 1; hit = 1; end
            else np = p + 2;
        end else begin
            if (p <= 2) begin np = 0; nd = 0; hit = 1; end
            else np = p - 2;
        end
    endtask

    // Drive one pixel for one clock, advance the model, compare everything.
    task automatic cycle(input int xx, input int yy, input bit en, input bit rst);
        int ec [3];
        bit fe, hit;
        int np, nd;
        x = 10'(xx); y = 10'(yy); enable = en; reset = rst;
        for (int i = 0; i < 3; i++) ec[i] = rst ? 0 : exp_colour(i, xx, yy);
        fe = (xx == 0 && yy == 480);
        @(posedge vga_clock);
        #1;
        if (rst) begin
            model_reset();
        end else if (moves_pending != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (moves_pending == 2) begin
                    axis_step(m_px[i], m_dx[i], 640, np, nd, hit);
                    m_px[i] = np; m_dx[i] = nd;
                end else begin
                    axis_step(m_py[i], m_dy[i], 480, np, nd, hit);
                    m_py[i] = np; m_dy[i] = nd;
                end
                if (hit) begin
                    m_col[i] = (m_col[i] + 1) % 64;
                    m_cnt[i] = (m_cnt[i] + 1) % 256;
                end
            end
            moves_pending--;
        end else if (fe && en) begin
            moves_pending = 2;
        end
        check("colour_a", int'(colour_a), ec[0]);
        check("colour_b", int'(colour_b), ec[1]);
        check("colour_c", int'(colour_c), ec[2]);
        check("count_a", int'(count_a), m_cnt[0]);
        check("count_b", int'(count_b), m_cnt[1]);
        check("count_c", int'(count_c), m_cnt[2]);
        check("px_a", int'(dut_a.px), m_px[0]);
        check("py_a", int'(dut_a.py), m_py[0]);
        check("px_b", int'(dut_b.px), m_px[1]);
        check("py_b", int'(dut_b.py), m_py[1]);
        check("px_c", int'(dut_c.px), m_px[2]);
        check("py_c", int'(dut_c.py), m_py[2]);
        check("boxcol_c", int'(dut_c.box_col_reg), m_col[2]);
    endtask

    task automatic frame_end_move(input bit en);
        cycle(0, 480, en, 0);
        cycle(0, 481, 0, 0);
        cycle(0, 482, 0, 0);
    endtask

    initial begin
        int k, xx, yy;
        model_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("rst_colour", int'(colour_a), 0);
        check("rst_count", int'(count_a), 0);

        // pixel path with defaults
        cycle(10, 10, 0, 0);
        check("pix_box", int'(colour_a), 6'b110000);
        cycle(100, 100, 0, 0);
        check("pix_bg", int'(colour_a), 6'b000001);
        cycle(700, 10, 0, 0);
        check("pix_blank", int'(colour_a), 0);

        // first move: px after 1 cycle, py after 2
        cycle(0, 480, 1, 0);
        cycle(0, 481, 0, 0);
        check("mv1_px_a", int'(dut_a.px), 2);
        check("mv1_py_a_hold", int'(dut_a.py), 0);
        cycle(0, 482, 0, 0);
        check("mv1_py_a", int'(dut_a.py), 2);
        check("mv1_cnt_a", int'(count_a), 0);
        check("mv1_px_b", int'(dut_b.px), 608);
        check("mv1_col_b", int'(dut_b.box_col_reg), 6'b110001);
        check("mv1_cnt_b", int'(count_b), 1);
        check("corner_px_c", int'(dut_c.px), 608);
        check("corner_py_c", int'(dut_c.py), 448);
        check("corner_col_c", int'(dut_c.box_col_reg), 6'b110010);
        check("corner_cnt_c", int'(count_c), 2);

        // second move: b comes back off the right edge
        frame_end_move(1);
        check("mv2_px_b", int'(dut_b.px), 606);
        check("mv2_px_a", int'(dut_a.px), 4);

        // frozen across three frame ends
        for (int f = 0; f < 3; f++) frame_end_move(0);
        check("frz_px_a", int'(dut_a.px), 4);
        check("frz_py_a", int'(dut_a.py), 4);
        check("frz_col_a", int'(dut_a.box_col_reg), 6'b110000);

        // enable raised mid-frame: nothing until the next frame end
        for (int c = 0; c < 5; c++) cycle(300 + c, 200, 1, 0);
        check("midf_px_a", int'(dut_a.px), 4);
        frame_end_move(1);
        check("en_px_a", int'(dut_a.px), 6);

        // reset while in S_MOVE_Y
        cycle(0, 480, 1, 0);
        cycle(0, 481, 0, 0);
        cycle(0, 482, 0, 1);
        check("rmv_px_a", int'(dut_a.px), 0);
        check("rmv_py_a", int'(dut_a.py), 0);
        check("rmv_px_b", int'(dut_b.px), 606);
        check("rmv_py_b", int'(dut_b.py), 100);
        check("rmv_cnt_b", int'(count_b), 0);
        check("rmv_state", int'(dut_a.state_reg == vga_pkg::S_DRAW), 1);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            k = int'($urandom_range(0, 9));
            if (k == 0) begin
                cycle(0, 480, ($urandom_range(0, 3) != 0), 0);
            end else if (k <= 3) begin
                // aim near one instance's box so edges of the box get hit
                xx = m_px[k - 1] + int'($urandom_range(0, 40)) - 4;
                yy = m_py[k - 1] + int'($urandom_range(0, 40)) - 4;
                if (xx < 0) xx = 0;
                if (yy < 0) yy = 0;
                cycle(xx, yy, ($urandom_range(0, 1) != 0), 0);
            end else begin
                cycle(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                      ($urandom_range(0, 1) != 0), ($urandom_range(0, 299) == 0));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bouncing_box_gen.md
# bouncing_box_gen

Pixel source that sits directly upstream of `vga_controller`. It consumes the controller's current pixel coordinates and returns the 6-bit `colour` for that pixel. The picture is a solid box on a flat background. The box moves a fixed step per frame and bounces off the visible-area edges. Its colour advances by one on every bounce. Position updates happen only in vertical blanking, so no frame ever shows a half-moved box.

## Interface
Parameters:
- `H_VIS`, 640, visible width in pixels
- `V_VIS`, 480, visible height in lines
- `BOX`, 32, box side in pixels; legal range 1 to `V_VIS`
- `STEP`, 2, pixels moved per axis per frame; legal range 1 to `V_VIS-BOX`
- `INIT_X`, 0, box left edge after reset; legal range 0 to `H_VIS-BOX`
- `INIT_Y`, 0, box top edge after reset; legal range 0 to `V_VIS-BOX`
- `BG_COLOUR`, 6'b000001, background colour

Ports (one clock; reset is synchronous and active-high):
- `vga_clock`  in  1  pixel clock, the same clock that drives `vga_controller`
- `reset`  in  1  synchronous, active-high
- `x`  in  10  current pixel column, counting through the blanking region
- `y`  in  10  current line, counting through the blanking region
- `enable`  in  1  1 = move each frame, 0 = freeze position and colour
- `colour`  out  6  pixel colour, packed RRGGBB, registered
- `bounce_count`  out  8  total bounces since reset; wraps 255 -> 0

## Operation
- Box state:
  - Position `px`, `py`, each 10 bits.
  - Direction bits `dx`, `dy`; 0 = increasing.
  - `box_col`, 6 bits.
- Pixel path:
  - If `x` >= `H_VIS` or `y` >= `V_VIS`, then `colour` = 0.
  - Else if `px` <= `x` < `px+BOX` and `py` <= `y` < `py+BOX`, then `colour` = `box_col`.
  - Otherwise `colour` = `BG_COLOUR`.
  - All sums are evaluated at 11 bits so they cannot overflow.
- Frame-end event: the cycle in which `x`==0 and `y`==`V_VIS`, with the FSM in `S_DRAW`.
- FSM states: `S_DRAW`, `S_MOVE_X`, `S_MOVE_Y`.
  - `S_DRAW` -> `S_MOVE_X` on a frame-end event when `enable`=1. Otherwise stay in `S_DRAW`.
  - `S_MOVE_X` -> `S_MOVE_Y` unconditionally. This state updates `px`/`dx`.
  - `S_MOVE_Y` -> `S_DRAW` unconditionally. This state updates `py`/`dy`.
- Axis update, shown for x; y is identical with `V_VIS`:
  - Moving up (`dx`=0): if `px+STEP` >= `H_VIS-BOX`, then `px` <= `H_VIS-BOX`, `dx` <= 1, and a bounce occurs. Otherwise `px` <= `px+STEP`.
  - Moving down (`dx`=1): if `px` <= `STEP`, then `px` <= 0, `dx` <= 0, and a bounce occurs. Otherwise `px` <= `px-STEP`.
  - Landing exactly on an edge counts as a bounce.
- On each bounce, `box_col` <= `box_col+1` (mod 64) and `bounce_count` <= `bounce_count+1` (mod 256).
  - A corner hit produces two bounces in consecutive cycles, so the total change is +2.
- `enable` is sampled only at the frame-end event. Changing it mid-frame has no visible effect until the next frame end.

## Timing
- Reset values:
  - `colour`=0, `bounce_count`=0.
  - `px`=`INIT_X`, `py`=`INIT_Y`, `dx`=`dy`=0.
  - `box_col`=6'b110000.
  - State `S_DRAW`.
- Pixel latency: `colour` reflects the `x`/`y` sampled one `vga_clock` edge earlier (1 cycle). `vga_controller` absorbs this delay.
- Move latency:
  - `px` changes one cycle after the frame-end cycle.
  - `py` changes two cycles after the frame-end cycle.
  - Both changes fall inside vertical blanking.
- Reset asserted mid-move (in `S_MOVE_X` or `S_MOVE_Y`): reset wins. All state returns to reset values on that edge, and the half-applied move is discarded.
- Back-to-back events cannot occur: the next frame-end event is a full frame later, and the FSM is already back in `S_DRAW` after 2 cycles.

## Structure
- Shared package `vga_pkg` holds:
  - `H_VIS`, `V_VIS` defaults.
  - The `colour_t` 6-bit type.
  - The RRGGBB field positions.
  - The FSM state enum.
- Sub-module `axis_mover` is instantiated twice, once for x and once for y.
  - Parameters: `LIMIT`, `BOX`, `STEP`, `INIT`.
  - Ports: `vga_clock`, `reset`, `step_en`, `pos`, `dir`, `bounce` (one-cycle pulse).
  - The top level holds the FSM, the colour/bounce counters and the pixel compare.

## Test plan
- Reset with defaults, then drive `x`=10, `y`=10 -> `colour`=6'b110000 one cycle later. Drive `x`=100, `y`=100 -> 6'b000001. Drive `x`=700, `y`=10 -> 0.
- `enable`=1, one frame-end event (`x`=0, `y`=480) -> `px`=2 after 1 cycle, `py`=2 after 2 cycles, `bounce_count`=0.
- `INIT_X`=606, `INIT_Y`=100, one frame end -> `px`=608, `dx`=1, `box_col`=6'b110001, `bounce_count`=1. Next frame end -> `px`=606.
- `INIT_X`=607, `INIT_Y`=447, `STEP`=2 -> corner hit: `px`=608, `py`=448, `box_col`=6'b110010, `bounce_count`=2.
- `enable`=0 across three frame-end events -> `px`, `py`, `box_col` unchanged. Raise `enable` mid-frame -> no move until the next frame end.
- Assert `reset` in the cycle the FSM is in `S_MOVE_Y` -> next cycle `px`=`INIT_X`, `py`=`INIT_Y`, state `S_DRAW`, `bounce_count`=0.
